// File: rtl/uart_pkg.sv
// Shared definitions for the UART AXI-Lite register front-end: register map,
// STATUS/CTRL bit positions, response codes and the address decoder.
package uart_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h00;
  localparam logic [31:0] OFF_RXDATA = 32'h04;
  localparam logic [31:0] OFF_STATUS = 32'h08;
  localparam logic [31:0] OFF_CTRL   = 32'h0C;
  localparam logic [31:0] OFF_BAUD   = 32'h10;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_LVL   = 8;
  localparam int ST_TX_LVL   = 16;

  localparam int CT_RX_IE    = 0;
  localparam int CT_TX_IE    = 1;
  localparam int CT_RX_FLUSH = 2;
  localparam int CT_TX_FLUSH = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_TXDATA, SEL_RXDATA, SEL_STATUS, SEL_CTRL, SEL_BAUD, SEL_NONE
  } reg_sel_e;

  // Byte-lane offset bits are ignored; only whole words are decoded.
  function automatic reg_sel_e reg_decode(input logic [31:0] a);
    reg_sel_e sel;
    case (a & ~32'h3)
      OFF_TXDATA: sel = SEL_TXDATA;
      OFF_RXDATA: sel = SEL_RXDATA;
      OFF_STATUS: sel = SEL_STATUS;
      OFF_CTRL:   sel = SEL_CTRL;
      OFF_BAUD:   sel = SEL_BAUD;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_axil_ctrl_if.sv
// AXI4-Lite slave bus for the UART front-end, plus read-only FSM state taps.
// valid/ready: a beat transfers on the rising edge where both are high; valid never drops before that.
interface uart_axil_ctrl_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [1:0]        dbg_wr_state;
  logic [0:0]        dbg_rd_state;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           dbg_wr_state, dbg_rd_state
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           dbg_wr_state, dbg_rd_state
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with saturating level; a push into a full FIFO succeeds only
// when a pop happens in the same cycle. Flush overrides push and pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int EXP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [EXP:0]     level
);
  localparam int DEPTH = 1 << EXP;
  localparam logic [EXP:0] FULL_LVL = (EXP+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [EXP-1:0]   wr_ptr_q, rd_ptr_q;
  logic [EXP:0]     level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign level   = level_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop & ~do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/uart_axil_ctrl.sv
// AXI4-Lite register front-end for the UART engines: TX/RX FIFOs, baud divisor,
// sticky error flags and a registered level interrupt.
module uart_axil_ctrl
  import uart_pkg::*;
#(
  parameter int          DBITS       = 8,
  parameter int          FIFO_EXP    = 4,
  parameter int          ADDR_W      = 5,
  parameter logic [15:0] DEFAULT_DIV = 16'd651
) (
  input  logic             s_axi_aclk,
  input  logic             reset,
  uart_axil_ctrl_if.slave  axi,
  output logic [DBITS-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [DBITS-1:0] rx_data,
  input  logic             rx_valid,
  output logic [15:0]      baud_div,
  output logic             irq
);
  localparam logic [1:0] W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_RESP = 1'b1;

  logic [1:0]        wr_state_q, wr_state_d;
  logic [0:0]        rd_state_q, rd_state_d;
  logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [15:0]       wdata_q, wdata_d, baud_q, baud_d, baud_tmp;
  logic [1:0]        wstrb_q, wstrb_d, bresp_q, bresp_d, rresp_q, rresp_d;
  logic              bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d, status;
  logic              rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;
  logic              rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
  logic              rx_ovr_clr, tx_ovf_clr, tx_ovf_set;
  logic              tx_push, tx_flush, tx_full, tx_empty;
  logic              rx_pop, rx_flush, rx_full, rx_empty;
  logic [FIFO_EXP:0] tx_level, rx_level;
  logic [DBITS-1:0]  tx_dout, rx_dout;
  reg_sel_e          wsel, rsel;

  uart_sync_fifo #(.WIDTH(DBITS), .EXP(FIFO_EXP)) u_tx_fifo (
    .clk(s_axi_aclk), .rst(reset), .push(tx_push), .pop(tx_ready), .flush(tx_flush),
    .din(wdata_q[DBITS-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.WIDTH(DBITS), .EXP(FIFO_EXP)) u_rx_fifo (
    .clk(s_axi_aclk), .rst(reset), .push(rx_valid), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    status = '0;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_LVL +: FIFO_EXP+1] = rx_level;
    status[ST_TX_LVL +: FIFO_EXP+1] = tx_level;
  end

  assign wsel = reg_decode(32'(awaddr_q));
  assign rsel = reg_decode(32'(axi.s_axi_araddr));

  always_comb begin
    wr_state_d = wr_state_q;  rd_state_d = rd_state_q;
    aw_full_d  = aw_full_q;   w_full_d   = w_full_q;
    awready_d  = 1'b0;        wready_d   = 1'b0;       arready_d = 1'b0;
    awaddr_d   = awaddr_q;    wdata_d    = wdata_q;    wstrb_d   = wstrb_q;
    bvalid_d   = bvalid_q;    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;    rdata_d    = rdata_q;    rresp_d   = rresp_q;
    rx_ie_d    = rx_ie_q;     tx_ie_d    = tx_ie_q;    baud_d    = baud_q;
    baud_tmp   = baud_q;
    tx_push    = 1'b0;        tx_flush   = 1'b0;       rx_flush  = 1'b0;
    rx_pop     = 1'b0;        tx_ovf_set = 1'b0;
    rx_ovr_clr = 1'b0;        tx_ovf_clr = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        awready_d = axi.s_axi_awvalid & ~aw_full_q & ~awready_q;
        wready_d  = axi.s_axi_wvalid  & ~w_full_q  & ~wready_q;
        if (axi.s_axi_awvalid & awready_q) begin
          aw_full_d = 1'b1;
          awaddr_d  = axi.s_axi_awaddr;
        end
        if (axi.s_axi_wvalid & wready_q) begin
          w_full_d = 1'b1;
          wdata_d  = axi.s_axi_wdata[15:0];
          wstrb_d  = axi.s_axi_wstrb[1:0];
        end
        if (aw_full_d & w_full_d) wr_state_d = W_EXEC;
      end
      W_EXEC: begin
        aw_full_d  = 1'b0;
        w_full_d   = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = RESP_OKAY;
        wr_state_d = W_RESP;
        case (wsel)
          SEL_TXDATA: if (wstrb_q[0]) begin
            // A full FIFO still accepts when the engine drains it this cycle.
            if (tx_full & ~tx_ready) begin
              tx_ovf_set = 1'b1;
              bresp_d    = RESP_SLVERR;
            end else begin
              tx_push = 1'b1;
            end
          end
          SEL_STATUS: if (wstrb_q[0]) begin
            rx_ovr_clr = wdata_q[ST_RX_OVR];
            tx_ovf_clr = wdata_q[ST_TX_OVF];
          end
          SEL_CTRL: if (wstrb_q[0]) begin
            rx_ie_d  = wdata_q[CT_RX_IE];
            tx_ie_d  = wdata_q[CT_TX_IE];
            rx_flush = wdata_q[CT_RX_FLUSH];
            tx_flush = wdata_q[CT_TX_FLUSH];
          end
          SEL_BAUD: begin
            if (wstrb_q[0]) baud_tmp[7:0]  = wdata_q[7:0];
            if (wstrb_q[1]) baud_tmp[15:8] = wdata_q[15:8];
            baud_d = (baud_tmp == 16'd0) ? 16'd1 : baud_tmp;
          end
          SEL_RXDATA: ;
          default: bresp_d = RESP_SLVERR;
        endcase
      end
      W_RESP: if (axi.s_axi_bready) begin
        bvalid_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    case (rd_state_q)
      R_IDLE: begin
        arready_d = axi.s_axi_arvalid & ~arready_q;
        if (axi.s_axi_arvalid & arready_q) begin
          rvalid_d   = 1'b1;
          rd_state_d = R_RESP;
          rresp_d    = RESP_OKAY;
          rdata_d    = '0;
          case (rsel)
            SEL_RXDATA: begin
              if (rx_empty) rdata_d = 32'h8000_0000;
              else begin
                rdata_d = 32'(rx_dout);
                rx_pop  = 1'b1;
              end
            end
            SEL_STATUS: rdata_d = status;
            SEL_CTRL:   rdata_d = {30'd0, tx_ie_q, rx_ie_q};
            SEL_BAUD:   rdata_d = {16'd0, baud_q};
            SEL_TXDATA: ;
            default:    rresp_d = RESP_SLVERR;
          endcase
        end
      end
      R_RESP: if (axi.s_axi_rready) begin
        rvalid_d   = 1'b0;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase

    // Setting a sticky flag outranks clearing it in the same cycle.
    rx_ovr_d = (rx_ovr_q & ~rx_ovr_clr) | (rx_valid & rx_full & ~rx_pop);
    tx_ovf_d = (tx_ovf_q & ~tx_ovf_clr) | tx_ovf_set;
    irq_d    = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | rx_ovr_q | tx_ovf_q;
  end

  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;   rd_state_q <= R_IDLE;
      aw_full_q  <= 1'b0;     w_full_q   <= 1'b0;
      awready_q  <= 1'b0;     wready_q   <= 1'b0;     arready_q <= 1'b0;
      awaddr_q   <= '0;       wdata_q    <= '0;       wstrb_q   <= '0;
      bvalid_q   <= 1'b0;     bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;     rdata_q    <= '0;       rresp_q   <= RESP_OKAY;
      rx_ie_q    <= 1'b0;     tx_ie_q    <= 1'b0;     baud_q    <= DEFAULT_DIV;
      rx_ovr_q   <= 1'b0;     tx_ovf_q   <= 1'b0;     irq_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d; rd_state_q <= rd_state_d;
      aw_full_q  <= aw_full_d;  w_full_q   <= w_full_d;
      awready_q  <= awready_d;  wready_q   <= wready_d;  arready_q <= arready_d;
      awaddr_q   <= awaddr_d;   wdata_q    <= wdata_d;   wstrb_q   <= wstrb_d;
      bvalid_q   <= bvalid_d;   bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;   rdata_q    <= rdata_d;   rresp_q   <= rresp_d;
      rx_ie_q    <= rx_ie_d;    tx_ie_q    <= tx_ie_d;   baud_q    <= baud_d;
      rx_ovr_q   <= rx_ovr_d;   tx_ovf_q   <= tx_ovf_d;  irq_q     <= irq_d;
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.dbg_wr_state  = wr_state_q;
  assign axi.dbg_rd_state  = rd_state_q;
  assign tx_data  = tx_dout;
  assign tx_valid = ~tx_empty;
  assign baud_div = baud_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_uart_axil_ctrl.sv
// Self-checking bench for uart_axil_ctrl: randomized traffic against a queue-based
// model of the FIFOs, sticky flags, control bits and baud register.
module tb_uart_axil_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, irq;
  logic [15:0] baud_div;

  always #5 clk = ~clk;

  uart_axil_ctrl_if #(.ADDR_W(5)) axi();

  uart_axil_ctrl #(.DBITS(8), .FIFO_EXP(4), .ADDR_W(5), .DEFAULT_DIV(16'd651)) dut (
    .s_axi_aclk(clk), .reset(rst), .axi(axi.slave),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .baud_div(baud_div), .irq(irq)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [7:0]  tx_m[$];
  logic [7:0]  rx_m[$];
  bit          rx_ovr_m, tx_ovf_m, rx_ie_m, tx_ie_m;
  logic [15:0] baud_m;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (rx_m.size() == 0);
    s[1] = (rx_m.size() == 16);
    s[2] = (tx_m.size() == 0);
    s[3] = (tx_m.size() == 16);
    s[4] = rx_ovr_m;
    s[5] = tx_ovf_m;
    s[15:8]  = 8'(rx_m.size());
    s[23:16] = 8'(tx_m.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return (rx_ie_m && rx_m.size() != 0) || (tx_ie_m && tx_m.size() == 0) || rx_ovr_m || tx_ovf_m;
  endfunction

  // Driver tasks (all start and end just after a falling edge)
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit to_aw, to_w;
    int n;
    to_aw = 0; to_w = 0;
    fork
      begin
        int k;
        k = 0;
        repeat (aw_dly) @(negedge clk);
        axi.s_axi_awaddr = addr; axi.s_axi_awvalid = 1'b1;
        while (!axi.s_axi_awready && k < 64) begin @(negedge clk); k++; end
        if (!axi.s_axi_awready) to_aw = 1;
        @(negedge clk); axi.s_axi_awvalid = 1'b0;
      end
      begin
        int k;
        k = 0;
        repeat (w_dly) @(negedge clk);
        axi.s_axi_wdata = data; axi.s_axi_wstrb = strb; axi.s_axi_wvalid = 1'b1;
        while (!axi.s_axi_wready && k < 64) begin @(negedge clk); k++; end
        if (!axi.s_axi_wready) to_w = 1;
        @(negedge clk); axi.s_axi_wvalid = 1'b0;
      end
    join
    n = 0;
    while (!axi.s_axi_bvalid && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (to_aw || to_w || !axi.s_axi_bvalid) begin
      failures++;
      $display("FAIL write_handshake addr=%h: aw_timeout=%0d w_timeout=%0d bvalid=%b, required all handshakes",
               addr, to_aw, to_w, axi.s_axi_bvalid);
    end
    resp = axi.s_axi_bresp;
    axi.s_axi_bready = 1'b1;
    @(negedge clk);
    axi.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    axi.s_axi_araddr = addr; axi.s_axi_arvalid = 1'b1;
    while (!axi.s_axi_arready && n < 64) begin @(negedge clk); n++; end
    @(negedge clk); axi.s_axi_arvalid = 1'b0;
    n = 0;
    while (!axi.s_axi_rvalid && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (!axi.s_axi_rvalid) begin
      failures++;
      $display("FAIL read_handshake addr=%h: rvalid=0, required 1", addr);
    end
    data = axi.s_axi_rdata; resp = axi.s_axi_rresp;
    repeat (hold) @(negedge clk);
    axi.s_axi_rready = 1'b1;
    @(negedge clk);
    axi.s_axi_rready = 1'b0;
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    if (rx_m.size() < 16) rx_m.push_back(d);
    else rx_ovr_m = 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1; tx_ready = 0; rx_valid = 0; rx_data = 0;
    axi.s_axi_awaddr = 0; axi.s_axi_awvalid = 0; axi.s_axi_wdata = 0; axi.s_axi_wstrb = 0;
    axi.s_axi_wvalid = 0; axi.s_axi_bready = 0; axi.s_axi_araddr = 0; axi.s_axi_arvalid = 0;
    axi.s_axi_rready = 0;
    tx_m.delete(); rx_m.delete();
    rx_ovr_m = 0; tx_ovf_m = 0; rx_ie_m = 0; tx_ie_m = 0; baud_m = 16'd651;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.s_axi_bvalid, axi.s_axi_rvalid, irq, tx_valid, axi.s_axi_awready, axi.s_axi_arready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {axi.s_axi_bvalid, axi.s_axi_rvalid, irq, tx_valid, axi.s_axi_awready, axi.s_axi_arready});
    end
    checks++;
    if (baud_div !== baud_m) begin
      failures++; $display("FAIL reset_baud_div: got %h required %h", baud_div, baud_m);
    end
    axi_read(5'h10, 0, d, r);
    checks++;
    if (d !== 32'h0000_028B || r !== 2'b00) begin
      failures++; $display("FAIL reset_baud_read: got %h/%b required 0000028b/00", d, r);
    end
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== 32'h0000_0005 || d !== exp_status()) begin
      failures++; $display("FAIL reset_status: got %h required 00000005", d);
    end
  endtask

  task automatic test_tx_single();
    logic [1:0] r;
    axi_write(5'h00, 32'h0000_0041, 4'hF, 0, 3, r);
    tx_m.push_back(8'h41);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL tx_single_resp: got %b required 00", r); end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      failures++; $display("FAIL tx_single_head: got valid=%b data=%h required 1/41", tx_valid, tx_data);
    end
    tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
    void'(tx_m.pop_front());
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_single_pop: tx_valid=%b required 0", tx_valid); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] wd, d; logic [1:0] r, er;
    for (int i = 0; i < 17; i++) begin
      wd = $urandom();
      if (tx_m.size() == 16) begin er = 2'b10; tx_ovf_m = 1; end
      else begin er = 2'b00; tx_m.push_back(wd[7:0]); end
      axi_write(5'h00, wd, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), r);
      checks++;
      if (r !== er) begin failures++; $display("FAIL tx_fill_resp[%0d]: got %b required %b", i, r, er); end
    end
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== exp_status()) begin failures++; $display("FAIL tx_full_status: got %h required %h", d, exp_status()); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL tx_ovf_irq: got %b required %b", irq, exp_irq()); end
    tx_ready = 1'b1;
    while (tx_m.size() != 0) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_m[0]) begin
        failures++; $display("FAIL tx_drain: got %b/%h required 1/%h", tx_valid, tx_data, tx_m[0]);
      end
      @(negedge clk);
      void'(tx_m.pop_front());
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained: tx_valid=%b required 0", tx_valid); end
    axi_write(5'h08, 32'h0000_0020, 4'hF, 1, 0, r);
    tx_ovf_m = 0;
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== exp_status()) begin failures++; $display("FAIL tx_ovf_w1c: got %h required %h", d, exp_status()); end
  endtask

  task automatic test_rx();
    logic [31:0] d; logic [1:0] r;
    rx_strobe(8'h5A);
    axi_read(5'h04, 0, d, r);
    checks++;
    if (d !== 32'h0000_005A || r !== 2'b00) begin failures++; $display("FAIL rx_read: got %h/%b required 0000005a/00", d, r); end
    void'(rx_m.pop_front());
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d[0] !== 1'b1 || d !== exp_status()) begin failures++; $display("FAIL rx_empty_status: got %h required %h", d, exp_status()); end
    axi_read(5'h04, 0, d, r);
    checks++;
    if (d !== 32'h8000_0000 || r !== 2'b00) begin failures++; $display("FAIL rx_read_empty: got %h/%b required 80000000/00", d, r); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 17; i++) rx_strobe(8'($urandom_range(0, 255)));
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || irq !== exp_irq()) begin failures++; $display("FAIL rx_ovr_irq: got %b required 1", irq); end
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== exp_status()) begin failures++; $display("FAIL rx_full_status: got %h required %h", d, exp_status()); end
    axi_write(5'h08, 32'h0000_0010, 4'hF, 0, 0, r);
    rx_ovr_m = 0;
    checks++;
    if (irq !== 1'b0 || irq !== exp_irq()) begin failures++; $display("FAIL rx_ovr_clear_irq: got %b required 0", irq); end
    while (rx_m.size() != 0) begin
      axi_read(5'h04, $urandom_range(0, 3), d, r);
      checks++;
      if (d !== {24'd0, rx_m[0]}) begin failures++; $display("FAIL rx_drain: got %h required %h", d, {24'd0, rx_m[0]}); end
      void'(rx_m.pop_front());
    end
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== exp_status()) begin failures++; $display("FAIL rx_drained_status: got %h required %h", d, exp_status()); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d; logic [1:0] r;
    axi_write(5'h0C, 32'h0000_0003, 4'hF, 0, 1, r);
    rx_ie_m = 1; tx_ie_m = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL ctrl_tx_ie_irq: got %b required %b", irq, exp_irq()); end
    rx_strobe(8'($urandom_range(0, 255)));
    rx_strobe(8'($urandom_range(0, 255)));
    axi_write(5'h00, $urandom(), 4'h1, 0, 0, r);
    axi_write(5'h00, $urandom(), 4'h1, 0, 0, r);
    tx_m.push_back(8'h00); tx_m.push_back(8'h00);
    axi_write(5'h0C, 32'h0000_0007, 4'hF, 2, 0, r);
    rx_m.delete();
    axi_read(5'h0C, 0, d, r);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL ctrl_flush_selfclear: got %h required 00000003", d); end
    axi_write(5'h0C, 32'h0000_0008, 4'hF, 0, 0, r);
    tx_m.delete(); rx_ie_m = 0; tx_ie_m = 0;
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== exp_status()) begin failures++; $display("FAIL ctrl_flush_status: got %h required %h", d, exp_status()); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL ctrl_irq_off: got %b required %b", irq, exp_irq()); end
  endtask

  task automatic test_misc();
    logic [31:0] d, d0; logic [1:0] r; int n; bit bad;
    axi_read(5'h1C, 0, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b10) begin failures++; $display("FAIL unmapped_read: got %h/%b required 0/10", d, r); end
    axi_write(5'h1C, $urandom(), 4'hF, 0, 0, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL unmapped_write: got %b required 10", r); end
    axi_write(5'h00, 32'h0000_00EE, 4'hE, 0, 0, r);
    checks++;
    if (r !== 2'b00 || tx_valid !== 1'b0) begin failures++; $display("FAIL tx_nostrb: got %b/%b required 00/0", r, tx_valid); end
    axi_write(5'h10, 32'h0000_1234, 4'hF, 0, 0, r);
    axi_write(5'h10, 32'h0000_AB00, 4'h2, 0, 0, r);
    baud_m = 16'hAB34;
    checks++;
    if (baud_div !== baud_m) begin failures++; $display("FAIL baud_bytes: got %h required %h", baud_div, baud_m); end
    axi_write(5'h10, 32'h0000_0000, 4'hF, 1, 0, r);
    baud_m = 16'd1;
    // Hold rready low with another read pending on AR.
    axi.s_axi_araddr = 5'h10; axi.s_axi_arvalid = 1'b1;
    n = 0;
    while (!axi.s_axi_arready && n < 64) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0;
    while (!axi.s_axi_rvalid && n < 64) begin @(negedge clk); n++; end
    d0 = axi.s_axi_rdata;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!axi.s_axi_rvalid || axi.s_axi_rdata !== d0 || axi.s_axi_arready) bad = 1;
    end
    checks++;
    if (d0 !== 32'd1) begin failures++; $display("FAIL baud_zero_read: got %h required 00000001", d0); end
    checks++;
    if (bad) begin failures++; $display("FAIL rvalid_hold: stable=0 required stable rvalid/rdata and no arready"); end
    axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b1;
    @(negedge clk);
    axi.s_axi_rready = 1'b0;
    @(negedge clk);
    checks++;
    if (axi.s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_release: got %b required 0", axi.s_axi_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, wd; logic [1:0] r, er;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          wd = $urandom();
          if (tx_m.size() == 16) begin er = 2'b10; tx_ovf_m = 1; end
          else begin er = 2'b00; tx_m.push_back(wd[7:0]); end
          axi_write(5'h00, wd, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3), r);
          checks++;
          if (r !== er) begin failures++; $display("FAIL b2b_tx_resp[%0d]: got %b required %b", i, r, er); end
        end
        1: rx_strobe(8'($urandom_range(0, 255)));
        2: begin
          axi_read(5'h04, $urandom_range(0, 2), d, r);
          checks++;
          if (rx_m.size() == 0) begin
            if (d !== 32'h8000_0000) begin failures++; $display("FAIL b2b_rx_empty[%0d]: got %h required 80000000", i, d); end
          end else begin
            if (d !== {24'd0, rx_m[0]}) begin failures++; $display("FAIL b2b_rx[%0d]: got %h required %h", i, d, {24'd0, rx_m[0]}); end
            void'(rx_m.pop_front());
          end
        end
        3: begin
          axi_read(5'h08, 0, d, r);
          checks++;
          if (d !== exp_status()) begin failures++; $display("FAIL b2b_status[%0d]: got %h required %h", i, d, exp_status()); end
        end
        default: if (tx_m.size() != 0) begin
          checks++;
          if (tx_valid !== 1'b1 || tx_data !== tx_m[0]) begin
            failures++; $display("FAIL b2b_tx_head[%0d]: got %b/%h required 1/%h", i, tx_valid, tx_data, tx_m[0]);
          end
          tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
          void'(tx_m.pop_front());
        end
      endcase
    end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL b2b_irq: got %b required %b", irq, exp_irq()); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_rx();
    test_rx_overflow();
    test_ctrl();
    test_misc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
